// File: rtl/cc_ben_stack.sv
// SLC-3 condition codes, branch enable and a LIFO of saved CC values.
// Optional taken-branch counter is built when BRANCH_STATS_EN is defined.
module cc_ben_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       LD_CC,
    input  logic                       LD_BEN,
    input  logic [WIDTH-1:0]           BUS_val,
    input  logic [2:0]                 IR_nzp,
    input  logic                       CC_push,
    input  logic                       CC_pop,
    output logic                       BEN_val,
    output logic [2:0]                 CC_out,
    output logic [$clog2(DEPTH+1)-1:0] stack_count,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       stack_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]           taken_cnt
`endif
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 1) begin : g_bad_depth
        $error("cc_ben_stack: DEPTH must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("cc_ben_stack: CNT_W must be >= 1");
    end

    logic [2:0]    cc_q;
    logic [2:0]    nzp_dec;
    logic [CW-1:0] cnt_q;
    logic [2:0]    stk [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          push_ok;
    logic          pop_ok;
    logic          err_set;
    logic          ben_calc;

    always_comb begin
        nzp_dec = 3'b001;
        unique case (1'b1)
            (BUS_val == '0):     nzp_dec = 3'b010;
            BUS_val[WIDTH-1]:    nzp_dec = 3'b100;
            default:             nzp_dec = 3'b001;
        endcase
    end

    assign stack_full  = (cnt_q == CW'(DEPTH));
    assign stack_empty = (cnt_q == '0);

    // Simultaneous push and pop is treated as a protocol error, not a swap.
    assign push_ok = CC_push & ~CC_pop & ~stack_full;
    assign pop_ok  = CC_pop & ~CC_push & ~stack_empty;
    assign err_set = (CC_push & CC_pop)
                   | (CC_push & ~CC_pop & stack_full)
                   | (CC_pop & ~CC_push & stack_empty);

    assign wr_idx   = IW'(cnt_q);
    assign rd_idx   = IW'(cnt_q - CW'(1));
    assign ben_calc = |(IR_nzp & cc_q);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cc_q <= 3'b010;
        end else if (pop_ok) begin
            cc_q <= stk[rd_idx];
        end else if (LD_CC) begin
            cc_q <= nzp_dec;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            BEN_val <= 1'b0;
        end else if (LD_BEN) begin
            BEN_val <= ben_calc;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (push_ok) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (pop_ok) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Stack storage needs no reset; only entries below the count are read.
    always_ff @(posedge Clk) begin
        if (!Reset && push_ok) begin
            stk[wr_idx] <= cc_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stack_err <= 1'b0;
        end else if (err_set) begin
            stack_err <= 1'b1;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            taken_cnt <= '0;
        end else if (LD_BEN && ben_calc && !(&taken_cnt)) begin
            taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end
`endif

    assign CC_out      = cc_q;
    assign stack_count = cnt_q;

endmodule
